// File: rtl/soc_boot_loader_if.sv
// soc_boot_loader_if: byte stream in, memory write port out, CPU start/finish handshake.
interface soc_boot_loader_if #(
    parameter int ADDR_W = 9
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [15:0]       ld_data;
    logic              cpu_start;
    logic              cpu_finish;
    modport master (
        input  in_valid, in_data, cpu_finish,
        output in_ready, ld_we, ld_addr, ld_data, cpu_start
    );
    modport slave (
        output in_valid, in_data, cpu_finish,
        input  in_ready, ld_we, ld_addr, ld_data, cpu_start
    );
endinterface

// File: rtl/soc_boot_loader.sv
// soc_boot_loader: loads a big-endian word image into SoC memory, starts the CPU and waits for finish or timeout.
module soc_boot_loader #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              go,
    soc_boot_loader_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int RUN_W = $clog2(TIMEOUT + 1);
    localparam logic [15:0] MAX_CNT = 16'(2 ** ADDR_W);

    typedef enum logic [3:0] {
        IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, START, RUN, DONE, ERR
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_W/2-1:0]     hi_q, hi_d;
    logic [DATA_W/2-1:0]     lo_q, lo_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [CNT_W-1:0]        rem_q, rem_d;
    logic [RUN_W-1:0]        run_q, run_d;
    logic [1:0]              err_q, err_d;
    logic                    rdy;
    logic                    acc;
    logic                    idle_like;
    logic                    timeout;
    logic [15:0]             count;

    assign rdy       = state_q inside {CNT_HI, CNT_LO, DAT_HI, DAT_LO};
    assign acc       = rdy && bus.in_valid;
    assign idle_like = state_q inside {IDLE, DONE, ERR};
    assign count     = {hi_q, bus.in_data};
    assign timeout   = run_q == RUN_W'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            run_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            run_q   <= run_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: state_d = go ? CNT_HI : state_q;
            CNT_HI:          state_d = acc ? CNT_LO : state_q;
            CNT_LO:          state_d = !acc ? state_q : (count == '0 || count > MAX_CNT) ? ERR : DAT_HI;
            DAT_HI:          state_d = acc ? DAT_LO : state_q;
            DAT_LO:          state_d = acc ? WRITE : state_q;
            WRITE:           state_d = rem_q == CNT_W'(1) ? START : DAT_HI;
            START:           state_d = RUN;
            RUN:             state_d = bus.cpu_finish ? DONE : timeout ? ERR : RUN;
            default:         state_d = IDLE;
        endcase
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        addr_d = addr_q;
        rem_d  = rem_q;
        err_d  = err_q;
        run_d  = state_q == RUN ? run_q + RUN_W'(1) : '0;
        if (idle_like && go) begin
            addr_d = '0;
            rem_d  = '0;
            err_d  = 2'd0;
        end
        if (acc && (state_q == CNT_HI || state_q == DAT_HI))
            hi_d = bus.in_data;
        if (acc && state_q == DAT_LO)
            lo_d = bus.in_data;
        if (acc && state_q == CNT_LO) begin
            rem_d = CNT_W'(count);
            err_d = count == '0 ? 2'd1 : count > MAX_CNT ? 2'd2 : 2'd0;
        end
        // the address stops on the last word so a full-memory image never wraps back to 0
        if (state_q == WRITE) begin
            rem_d  = rem_q - CNT_W'(1);
            addr_d = rem_q == CNT_W'(1) ? addr_q : addr_q + ADDR_W'(1);
        end
        if (state_q == RUN && !bus.cpu_finish && timeout)
            err_d = 2'd3;
    end

    always_comb begin
        bus.in_ready  = rdy;
        bus.ld_we     = state_q == WRITE;
        bus.ld_addr   = addr_q;
        bus.ld_data   = {hi_q, lo_q};
        bus.cpu_start = state_q == START;
        busy          = !idle_like;
        done          = state_q == DONE;
        error         = state_q == ERR;
        err_code      = err_q;
    end
endmodule

// File: tb/tb_soc_boot_loader.sv
// tb_soc_boot_loader: directed load, error, timeout and reset-abort sessions with hand-computed expectations.
module tb_soc_boot_loader;
    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 20;

    logic       clk   = 1'b0;
    logic       rst_b = 1'b1;
    logic       go    = 1'b0;
    logic       busy, done, error;
    logic [1:0] err_code;
    int         errors = 0, checks = 0;
    int         wr_cnt = 0, start_cnt = 0, rdy_in_wr = 0;
    int         base_wr, base_st;
    logic [15:0] mem [2 ** ADDR_W];
    logic [15:0] img [13] = '{16'h0407, 16'h0A08, 16'h1409, 16'h0C0A, 16'h120B, 16'h180C, 16'h0000,
                              16'h1234, 16'h1235, 16'h1236, 16'h1237, 16'h1238, 16'h1239};
    int          gaps [8] = '{1, 3, 5, 2, 4, 1, 5, 3};
    logic [15:0] gw [3]   = '{16'h1111, 16'h2222, 16'h3333};

    soc_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    soc_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_b(rst_b), .go(go), .bus(bus),
        .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.ld_we) begin
            mem[bus.ld_addr] <= bus.ld_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.cpu_start) start_cnt <= start_cnt + 1;
        if (bus.ld_we && bus.in_ready) rdy_in_wr <= rdy_in_wr + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        bus.in_valid = 1'b0;
        repeat (gap) tick;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 100) begin
            tick;
            n++;
        end
        if (n >= 100) check("accept_timeout", 0, 1);
        tick;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input int g_hi, input int g_lo);
        send_byte(w[15:8], g_hi);
        send_byte(w[7:0], g_lo);
    endtask

    task automatic pulse_go;
        go = 1'b1;
        tick;
        go = 1'b0;
    endtask

    task automatic wait_start;
        int n = 0;
        while (!bus.cpu_start && n < 10) begin
            tick;
            n++;
        end
        check("start_seen", bus.cpu_start, 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_ld_we"}, bus.ld_we, 0);
        check({tag, "_cpu_start"}, bus.cpu_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_ld_addr"}, bus.ld_addr, 0);
        check({tag, "_ld_data"}, bus.ld_data, 0);
        check({tag, "_err_code"}, err_code, 0);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.cpu_finish = 1'b0;
        #2 rst_b = 1'b0;
        #1 check_reset("rst");
        tick;
        rst_b = 1'b1;
        tick;

        // full 13-word image
        base_wr = wr_cnt;
        base_st = start_cnt;
        pulse_go;
        check("main_busy", busy, 1);
        send_byte(8'h00, 0);
        send_byte(8'h0D, 0);
        for (int i = 0; i < 13; i++) send_word(img[i], 0, 0);
        wait_start;
        check("main_writes", wr_cnt - base_wr, 13);
        for (int i = 0; i < 13; i++) check($sformatf("main_mem%0d", i), mem[i], img[i]);
        tick;
        check("main_run_busy", busy, 1);
        bus.cpu_finish = 1'b1;
        tick;
        bus.cpu_finish = 1'b0;
        check("main_done", done, 1);
        check("main_error", error, 0);
        check("main_idle", busy, 0);
        check("main_starts", start_cnt - base_st, 1);
        check("main_last_addr", bus.ld_addr, 12);

        // zero count
        base_wr = wr_cnt;
        base_st = start_cnt;
        pulse_go;
        check("zero_done_cleared", done, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("zero_error", error, 1);
        check("zero_code", err_code, 1);
        check("zero_busy", busy, 0);
        tick;
        check("zero_writes", wr_cnt - base_wr, 0);
        check("zero_starts", start_cnt - base_st, 0);

        // count 0x201 overflows, 0x200 is accepted
        pulse_go;
        check("ovf_code_cleared", err_code, 0);
        check("ovf_error_cleared", error, 0);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        check("ovf_error", error, 1);
        check("ovf_code", err_code, 2);
        pulse_go;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        check("max_error", error, 0);
        check("max_busy", busy, 1);
        check("max_ready", bus.in_ready, 1);
        rst_b = 1'b0;
        #1 check_reset("max_abort");
        tick;
        rst_b = 1'b1;
        tick;

        // run timeout exactly TIMEOUT cycles after RUN entry
        pulse_go;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(16'hABCD, 0, 0);
        wait_start;
        check("to_mem0", mem[0], 16'hABCD);
        repeat (TIMEOUT) tick;
        check("to_pre_error", error, 0);
        check("to_pre_busy", busy, 1);
        tick;
        check("to_error", error, 1);
        check("to_code", err_code, 3);

        // finish on the last RUN cycle wins over timeout
        pulse_go;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(16'h5A5A, 0, 0);
        wait_start;
        repeat (TIMEOUT) tick;
        bus.cpu_finish = 1'b1;
        tick;
        bus.cpu_finish = 1'b0;
        check("race_done", done, 1);
        check("race_error", error, 0);
        check("race_code", err_code, 0);

        // stalled stream
        base_wr = wr_cnt;
        pulse_go;
        send_byte(8'h00, gaps[0]);
        send_byte(8'h03, gaps[1]);
        for (int i = 0; i < 3; i++) send_word(gw[i], gaps[2 + 2 * i], gaps[3 + 2 * i]);
        wait_start;
        check("gap_writes", wr_cnt - base_wr, 3);
        for (int i = 0; i < 3; i++) check($sformatf("gap_mem%0d", i), mem[i], gw[i]);
        tick;
        bus.cpu_finish = 1'b1;
        tick;
        bus.cpu_finish = 1'b0;
        check("gap_done", done, 1);

        // reset after two of four words, then a clean reload
        base_wr = wr_cnt;
        base_st = start_cnt;
        pulse_go;
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_word(16'hA001, 0, 0);
        send_word(16'hA002, 0, 0);
        check("abort_writes", wr_cnt - base_wr, 2);
        #2 rst_b = 1'b0;
        #1 check_reset("abort");
        tick;
        rst_b = 1'b1;
        tick;
        check("abort_starts", start_cnt - base_st, 0);
        base_wr = wr_cnt;
        pulse_go;
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        for (int i = 0; i < 4; i++) send_word(16'hB001 + 16'(i), 0, 0);
        wait_start;
        check("reload_writes", wr_cnt - base_wr, 4);
        for (int i = 0; i < 4; i++) check($sformatf("reload_mem%0d", i), mem[i], 16'hB001 + 16'(i));
        tick;
        bus.cpu_finish = 1'b1;
        tick;
        bus.cpu_finish = 1'b0;
        check("reload_done", done, 1);
        check("ready_in_write", rdy_in_wr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
